// File: rtl/x_demux2_stream_pkg.sv
// x_stream_pkg: shared mode/destination encodings for the stream mux/demux family
package x_stream_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_ALT = 1'b1;
  localparam logic DEST_A = 1'b0;
  localparam logic DEST_B = 1'b1;
endpackage

// File: rtl/x_demux2_stream_if.sv
// x_demux2_stream_if: input stream, steering controls and both output streams of the demux
interface x_demux2_stream_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] i;
  logic i_vld;
  logic i_rdy;
  logic sel;
  logic mode;
  logic [WIDTH-1:0] oa;
  logic oa_vld;
  logic oa_rdy;
  logic [WIDTH-1:0] ob;
  logic ob_vld;
  logic ob_rdy;
  logic phase;
  modport master (output i, i_vld, sel, mode, oa_rdy, ob_rdy, input i_rdy, oa, oa_vld, ob, ob_vld, phase);
  modport slave (input i, i_vld, sel, mode, oa_rdy, ob_rdy, output i_rdy, oa, oa_vld, ob, ob_vld, phase);
endinterface

// File: rtl/x_demux2_stream_fifo.sv
// x_stream_fifo: small synchronous FIFO; dout shows the head, or the last popped word when empty
module x_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [WIDTH-1:0] last;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = empty ? last : mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      last <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/x_demux2_stream.sv
// x_demux2_stream: 1-to-2 stream demux, SEL-steered or alternating, with a FIFO per output
module x_demux2_stream
  import x_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  x_demux2_stream_if.slave s
);
  logic phase_q, dest, acc, full_a, full_b, empty_a, empty_b;
  logic [WIDTH-1:0] din, oa_d, ob_d;
  assign dest = s.mode == MODE_ALT ? phase_q : s.sel;
  // ready depends only on the destination's fullness, never on the consumers
  assign s.i_rdy = ~rst & (dest == DEST_B ? ~full_b : ~full_a);
  assign acc = s.i_vld & s.i_rdy;
  assign din = s.i;
  assign s.oa = oa_d;
  assign s.ob = ob_d;
  assign s.oa_vld = ~empty_a;
  assign s.ob_vld = ~empty_b;
  assign s.phase = phase_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= DEST_A;
    else if (acc & (s.mode == MODE_ALT)) phase_q <= ~phase_q;
  end
  x_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push(acc & (dest == DEST_A)), .din(din),
    .pop(s.oa_rdy), .dout(oa_d), .empty(empty_a), .full(full_a)
  );
  x_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push(acc & (dest == DEST_B)), .din(din),
    .pop(s.ob_rdy), .dout(ob_d), .empty(empty_b), .full(full_b)
  );
endmodule

// File: tb/tb_x_demux2_stream.sv
// tb_x_demux2_stream: directed steps with hand-computed expectations for the 2-way stream demux
module tb_x_demux2_stream;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  x_demux2_stream_if #(.WIDTH(8)) bus ();
  x_demux2_stream #(.WIDTH(8), .DEPTH(2)) dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.i = '0;
    bus.i_vld = 1'b0;
    bus.sel = 1'b0;
    bus.mode = 1'b0;
    bus.oa_rdy = 1'b0;
    bus.ob_rdy = 1'b0;
    #3;
    chk("rst_irdy", 8'(bus.i_rdy), 8'h0);
    chk("rst_oa_vld", 8'(bus.oa_vld), 8'h0);
    chk("rst_oa", bus.oa, 8'h00);
    chk("rst_ob", bus.ob, 8'h00);
    chk("rst_phase", 8'(bus.phase), 8'h0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rel_irdy", 8'(bus.i_rdy), 8'h1);
    // SEL-steered: 11->A, 22->B, 33->A
    bus.oa_rdy = 1'b1;
    bus.ob_rdy = 1'b1;
    bus.i_vld = 1'b1;
    bus.sel = 1'b0;
    bus.i = 8'h11;
    tick;
    chk("sel_oa_vld1", 8'(bus.oa_vld), 8'h1);
    chk("sel_oa1", bus.oa, 8'h11);
    chk("sel_ob_vld0", 8'(bus.ob_vld), 8'h0);
    bus.sel = 1'b1;
    bus.i = 8'h22;
    tick;
    chk("sel_ob_vld", 8'(bus.ob_vld), 8'h1);
    chk("sel_ob", bus.ob, 8'h22);
    chk("sel_oa_empty", 8'(bus.oa_vld), 8'h0);
    chk("sel_oa_last", bus.oa, 8'h11);
    bus.sel = 1'b0;
    bus.i = 8'h33;
    tick;
    chk("sel_oa3", bus.oa, 8'h33);
    chk("sel_oa_vld3", 8'(bus.oa_vld), 8'h1);
    chk("sel_ob_drained", 8'(bus.ob_vld), 8'h0);
    chk("sel_phase_hold", 8'(bus.phase), 8'h0);
    bus.i_vld = 1'b0;
    tick;
    // alternate mode: 01..06 -> A gets odd, B gets even
    bus.mode = 1'b1;
    bus.i_vld = 1'b1;
    bus.i = 8'h01; tick; chk("alt_oa01", bus.oa, 8'h01); chk("alt_ph1", 8'(bus.phase), 8'h1);
    bus.i = 8'h02; tick; chk("alt_ob02", bus.ob, 8'h02); chk("alt_ph2", 8'(bus.phase), 8'h0);
    bus.i = 8'h03; tick; chk("alt_oa03", bus.oa, 8'h03);
    bus.i = 8'h04; tick; chk("alt_ob04", bus.ob, 8'h04);
    bus.i = 8'h05; tick; chk("alt_oa05", bus.oa, 8'h05); chk("alt_oa_vld5", 8'(bus.oa_vld), 8'h1);
    bus.i = 8'h06; tick; chk("alt_ob06", bus.ob, 8'h06); chk("alt_ob_vld6", 8'(bus.ob_vld), 8'h1);
    bus.i_vld = 1'b0;
    tick;
    chk("alt_phase_end", 8'(bus.phase), 8'h0);
    chk("alt_drained", 8'({bus.oa_vld, bus.ob_vld}), 8'h0);
    // fill B with ready low, third word stalls
    bus.mode = 1'b0;
    bus.sel = 1'b1;
    bus.ob_rdy = 1'b0;
    bus.i_vld = 1'b1;
    bus.i = 8'hAA; tick;
    bus.i = 8'hBB; tick;
    bus.i = 8'hCC;
    #1;
    chk("full_b_irdy", 8'(bus.i_rdy), 8'h0);
    tick;
    chk("full_b_head", bus.ob, 8'hAA);
    bus.sel = 1'b0;
    #1;
    chk("to_a_irdy", 8'(bus.i_rdy), 8'h1);
    tick;
    chk("to_a_oa", bus.oa, 8'hCC);
    chk("to_a_vld", 8'(bus.oa_vld), 8'h1);
    bus.i_vld = 1'b0;
    tick;
    // full B popped and pushed in the same cycle: push refused
    bus.sel = 1'b1;
    bus.i = 8'hDD;
    bus.i_vld = 1'b1;
    bus.ob_rdy = 1'b1;
    #1;
    chk("fullpop_irdy", 8'(bus.i_rdy), 8'h0);
    tick;
    chk("fullpop_ob", bus.ob, 8'hBB);
    chk("fullpop_irdy_next", 8'(bus.i_rdy), 8'h1);
    tick;
    chk("fullpop_ob_new", bus.ob, 8'hDD);
    chk("fullpop_ob_vld", 8'(bus.ob_vld), 8'h1);
    bus.i_vld = 1'b0;
    tick;
    chk("fullpop_ob_empty", 8'(bus.ob_vld), 8'h0);
    chk("fullpop_ob_last", bus.ob, 8'hDD);
    // PHASE retained across a MODE=0 interlude
    bus.mode = 1'b1;
    bus.i_vld = 1'b1;
    bus.i = 8'h44;
    tick;
    chk("ret_oa44", bus.oa, 8'h44);
    chk("ret_phase1", 8'(bus.phase), 8'h1);
    bus.mode = 1'b0;
    bus.sel = 1'b0;
    bus.i = 8'h50; tick;
    bus.i = 8'h51; tick;
    bus.i = 8'h52; tick;
    chk("ret_oa52", bus.oa, 8'h52);
    chk("ret_phase_held", 8'(bus.phase), 8'h1);
    bus.mode = 1'b1;
    bus.i = 8'h66;
    tick;
    chk("ret_ob66", bus.ob, 8'h66);
    chk("ret_ob_vld", 8'(bus.ob_vld), 8'h1);
    chk("ret_phase0", 8'(bus.phase), 8'h0);
    // mid-stream reset with two words queued in A and PHASE=1
    bus.oa_rdy = 1'b0;
    bus.i = 8'h70; tick;
    bus.mode = 1'b0;
    bus.i = 8'h71; tick;
    bus.i_vld = 1'b0;
    chk("mid_oa_vld", 8'(bus.oa_vld), 8'h1);
    chk("mid_phase", 8'(bus.phase), 8'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_oa_vld", 8'(bus.oa_vld), 8'h0);
    chk("mid_rst_oa", bus.oa, 8'h00);
    chk("mid_rst_phase", 8'(bus.phase), 8'h0);
    chk("mid_rst_irdy", 8'(bus.i_rdy), 8'h0);
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rel_irdy", 8'(bus.i_rdy), 8'h1);
    chk("mid_rel_oa_vld", 8'(bus.oa_vld), 8'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
